// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end for the 5-stage MIPS core.
// Issues sequential word fetches to a variable-latency instruction memory,
// buffers returned words with their PC+4 in a small in-order prefetch FIFO,
// and hands them to decode under a valid/ready handshake. A redirect flushes
// the FIFO, marks in-flight responses for discard and restarts fetch.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc4,
  input  logic        decode_ready
);

  localparam int            PW        = $clog2(DEPTH);
  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_SUM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  // Next address to request, and the address of the next response we keep.
  logic [31:0] fetchPc;
  logic [31:0] respPc;
  logic [31:0] redirectTarget;
  logic [31:0] pushPc4;

  // Prefetch FIFO storage and bookkeeping.
  logic [31:0]   fifoInstr [DEPTH];
  logic [31:0]   fifoPc4   [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] count;

  // Requests accepted by memory: those we will keep and those we will drop.
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic [CW:0]   fillLevel;
  logic [CW:0]   inFlight;
  logic [CW-1:0] discardOnRedirect;
  logic          accept;
  logic          respAny;
  logic          respDrop;
  logic          respKeep;
  logic          doPop;
  logic          unusedLowBits;

  assign redirectTarget = {redirect_pc[31:2], 2'b00};
  assign unusedLowBits  = ^redirect_pc[1:0];
  assign pushPc4        = respPc + 32'd4;
  assign imem_addr      = fetchPc;

  // Credit check: never let buffered + pending-keep exceed the FIFO, and never
  // let total memory-side requests exceed DEPTH. Held off during reset/redirect.
  always_comb begin
    fillLevel = {1'b0, count} + {1'b0, outstanding};
    inFlight  = {1'b0, outstanding} + {1'b0, discard};
    imem_req  = !reset && !redirect_valid &&
                (fillLevel < DEPTH_SUM) && (inFlight < DEPTH_SUM);
    accept    = imem_req && imem_ack;
  end

  // Classify a returning response: dropped if older than the last redirect,
  // kept otherwise; a response with nothing pending is ignored.
  always_comb begin
    respAny           = imem_rvalid && (inFlight != '0);
    respDrop          = imem_rvalid && (discard != '0);
    respKeep          = imem_rvalid && (discard == '0) && (outstanding != '0) &&
                        !redirect_valid;
    discardOnRedirect = CW'(inFlight - {{CW{1'b0}}, respAny});
  end

  // Head of the FIFO is presented to decode; hidden in a redirect cycle.
  always_comb begin
    instr_valid = (count != '0) && !redirect_valid;
    doPop       = instr_valid && decode_ready;
    instr       = fifoInstr[rdPtr];
    instr_pc4   = fifoPc4[rdPtr];
  end

  // Fetch address and response-address tracking, both retargeted by redirect.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchPc <= RESET_PC;
      respPc  <= RESET_PC;
    end else if (redirect_valid) begin
      fetchPc <= redirectTarget;
      respPc  <= redirectTarget;
    end else begin
      if (accept) begin
        fetchPc <= fetchPc + 32'd4;
      end
      if (respKeep) begin
        respPc <= pushPc4;
      end
    end
  end

  // Keep/drop credit counters; redirect moves everything pending to discard.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      outstanding <= '0;
      discard     <= discardOnRedirect;
    end else begin
      case ({accept, respKeep})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (respDrop) begin
        discard <= discard - CW'(1);
      end
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue outright.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (respKeep) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({respKeep, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: a kept response is written with the PC+4 of its address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifoInstr[i] <= '0;
        fifoPc4[i]   <= '0;
      end
    end else if (respKeep) begin
      fifoInstr[wrPtr] <= imem_rdata;
      fifoPc4[wrPtr]   <= pushPc4;
    end
  end

  // The credit rule guarantees a kept response always finds a free slot.
  assert property (@(posedge clock) disable iff (reset)
                   !(respKeep && (count == DEPTH_CNT)));

endmodule
